// File: rtl/mod_updown_counter_if.sv
// Bundle of the up/down counter's control inputs and status outputs.
// The master drives the controls; the counter (slave) drives the status.
interface mod_updown_counter_if #(
  parameter int N = 4
);
  logic         enable;
  logic         clear;
  logic         load;
  logic [N-1:0] load_value;
  logic         up;
  logic [N-1:0] limit;
  logic         saturate;
  logic [N-1:0] out;
  logic         at_max;
  logic         at_zero;
  logic         wrap;
  logic         sat_flag;

  modport master (
    output enable, clear, load, load_value, up, limit, saturate,
    input  out, at_max, at_zero, wrap, sat_flag
  );

  modport slave (
    input  enable, clear, load, load_value, up, limit, saturate,
    output out, at_max, at_zero, wrap, sat_flag
  );
endinterface

// File: rtl/mod_updown_counter.sv
// N-bit up/down counter with programmable terminal value (range 0..limit),
// synchronous clear/load, wrap or saturate mode, a one-cycle wrap pulse
// and a sticky flag for steps blocked by saturation.
module mod_updown_counter #(
  parameter int N = 4
) (
  input  logic                clock,
  input  logic                reset,
  mod_updown_counter_if.slave bus
);

  logic [N-1:0] out_q, out_d;
  logic         wrap_q, wrap_d;
  logic         sat_q, sat_d;

  // Next-state: clear > load > enable > hold; wrap is a pulse so it defaults low.
  always_comb begin
    out_d  = out_q;
    wrap_d = 1'b0;
    sat_d  = sat_q;
    if (bus.clear) begin
      out_d = '0;
      sat_d = 1'b0;
    end else if (bus.load) begin
      out_d = bus.load_value;
      sat_d = 1'b0;
    end else if (bus.enable) begin
      if (bus.up) begin
        if (out_q < bus.limit) begin
          out_d = out_q + 1'b1;
        end else if (bus.saturate) begin
          out_d = bus.limit;
          sat_d = 1'b1;
        end else begin
          out_d  = '0;
          wrap_d = 1'b1;
        end
      end else begin
        // An over-range value is pulled back to limit without raising a flag.
        if (out_q > bus.limit) begin
          out_d = bus.limit;
        end else if (out_q != '0) begin
          out_d = out_q - 1'b1;
        end else if (bus.saturate) begin
          out_d = '0;
          sat_d = 1'b1;
        end else begin
          out_d  = bus.limit;
          wrap_d = 1'b1;
        end
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_q  <= '0;
      wrap_q <= 1'b0;
      sat_q  <= 1'b0;
    end else begin
      out_q  <= out_d;
      wrap_q <= wrap_d;
      sat_q  <= sat_d;
    end
  end

  assign bus.out      = out_q;
  assign bus.wrap     = wrap_q;
  assign bus.sat_flag = sat_q;
  assign bus.at_max   = (out_q >= bus.limit);
  assign bus.at_zero  = (out_q == '0);

endmodule
